// File: rtl/sprite_pkg.sv
// ============================================================================
// sprite_pkg
// ----------------------------------------------------------------------------
// Shared definitions for the sprite pixel sources of the VGA pipeline.
//
// Contents:
//   SCREEN_W / SCREEN_H : visible raster size in pixels
//   coord_t             : 10-bit screen coordinate (matches DrawX/DrawY)
//   coord_wide_t        : 11-bit coordinate used for edge arithmetic so that
//                         sprite edges near the right/bottom border do not wrap
//   shadow_t            : per-frame snapshot of the sprite placement controls
//   sprite_addr()       : texel address of (frame,row,col) with optional
//                         horizontal mirroring, for power-of-two sprite sizes
// ============================================================================
package sprite_pkg;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    typedef logic [9:0]  coord_t;
    typedef logic [10:0] coord_wide_t;

    // Placement controls captured once per video frame so a whole frame is
    // drawn with one consistent set of values.
    typedef struct packed {
        coord_t x;
        coord_t y;
        logic   en;
        logic   flip;
        logic   anim;
    } shadow_t;

    // Frames are stored back to back, each frame row-major. Because width and
    // height are powers of two every product collapses to a shift, so the
    // result is just the three fields concatenated. Mirroring reflects the
    // column inside the sprite width. The caller truncates to its ROM width.
    function automatic int unsigned sprite_addr(
        input int unsigned frame,
        input int unsigned row,
        input int unsigned col,
        input logic        flip,
        input int unsigned w_log2,
        input int unsigned h_log2
    );
        int unsigned c;
        c = flip ? (((32'd1 << w_log2) - 32'd1) - col) : col;
        return (frame << (w_log2 + h_log2)) | (row << w_log2) | c;
    endfunction

endpackage

// File: rtl/sprite_anim_ctrl.sv
// ============================================================================
// sprite_anim_ctrl
// ----------------------------------------------------------------------------
// Per-frame control for the sprite blitter: detects the start of each video
// frame, snapshots the placement controls into shadow registers and steps the
// animation frame index.
//
// Ports:
//   vga_clk      in   pixel clock, all logic on posedge
//   reset_n      in   synchronous active-low reset
//   DrawX/DrawY  in   current raster position
//   sprite_x/y   in   requested top-left corner of the sprite
//   sprite_en    in   request sprite visible
//   flip_h       in   request horizontal mirror
//   anim_en      in   1 = auto-animate, 0 = use frame_sel
//   frame_sel    in   static frame when not animating
//   frame_start  out  registered one-cycle pulse after (0,0) is sampled
//   sx, sy       out  shadowed sprite position
//   s_en, s_flip out  shadowed enable / mirror
//   frame_idx    out  animation frame currently displayed
// ============================================================================
module sprite_anim_ctrl
    import sprite_pkg::*;
#(
    parameter int NUM_FRAMES  = 4,
    parameter int FRAME_TICKS = 8,
    localparam int FSEL_W = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
    input  logic              vga_clk,
    input  logic              reset_n,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic [9:0]        sprite_x,
    input  logic [9:0]        sprite_y,
    input  logic              sprite_en,
    input  logic              flip_h,
    input  logic              anim_en,
    input  logic [FSEL_W-1:0] frame_sel,
    output logic              frame_start,
    output coord_t            sx,
    output coord_t            sy,
    output logic              s_en,
    output logic              s_flip,
    output logic [FSEL_W-1:0] frame_idx
);

    localparam int          TICK_W    = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
    localparam int unsigned TICK_LAST = FRAME_TICKS - 1;
    localparam int unsigned LAST_FRM  = NUM_FRAMES - 1;

    shadow_t           shadow;
    logic [FSEL_W-1:0] frame_sel_s;
    logic [FSEL_W-1:0] frame_sel_clamped;
    logic [TICK_W-1:0] tick_cnt;
    logic              at_origin;

    assign at_origin = (DrawX == 10'd0) && (DrawY == 10'd0);

    // A frame_sel code beyond the stored frames would read past the sprite
    // data, so it is pinned to the last frame instead.
    always_comb begin
        frame_sel_clamped = frame_sel_s;
        if (32'(frame_sel_s) > LAST_FRM)
            frame_sel_clamped = FSEL_W'(LAST_FRM);
    end

    // Everything here moves only at frame start. The animation step looks at
    // the shadows captured at the previous frame start, so a new anim_en or
    // frame_sel value is acted on one frame after it is latched. The tick
    // wrap and the index step share one branch, so a wrap on a frame start
    // advances the index exactly once.
    always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
            frame_start <= 1'b0;
            shadow      <= '0;
            frame_sel_s <= '0;
            tick_cnt    <= '0;
            frame_idx   <= '0;
        end else begin
            frame_start <= at_origin;
            if (at_origin) begin
                shadow.x    <= sprite_x;
                shadow.y    <= sprite_y;
                shadow.en   <= sprite_en;
                shadow.flip <= flip_h;
                shadow.anim <= anim_en;
                frame_sel_s <= frame_sel;
                if (shadow.anim) begin
                    if (32'(tick_cnt) >= TICK_LAST) begin
                        tick_cnt <= '0;
                        if (32'(frame_idx) >= LAST_FRM)
                            frame_idx <= '0;
                        else
                            frame_idx <= frame_idx + 1'b1;
                    end else begin
                        tick_cnt <= tick_cnt + 1'b1;
                    end
                end else begin
                    tick_cnt  <= '0;
                    frame_idx <= frame_sel_clamped;
                end
            end
        end
    end

    assign sx     = shadow.x;
    assign sy     = shadow.y;
    assign s_en   = shadow.en;
    assign s_flip = shadow.flip;

endmodule

// File: rtl/sprite_blitter.sv
// ============================================================================
// sprite_blitter
// ----------------------------------------------------------------------------
// Sprite pixel source for the VGA pipeline. Places an animated, optionally
// mirrored and power-of-two scaled sprite at a runtime position, fetches its
// texels from an external synchronous ROM and hands a palette index plus an
// opaque flag to the mixer. Latency from DrawX/DrawY/blank to pix_*/blank_d
// is a fixed two cycles.
//
// Ports:
//   vga_clk      in   pixel clock, all logic on posedge
//   reset_n      in   synchronous active-low reset
//   DrawX/DrawY  in   current raster position
//   blank        in   1 = active video
//   sprite_x/y   in   requested top-left corner, screen pixels
//   sprite_en    in   request sprite visible
//   flip_h       in   mirror horizontally
//   anim_en      in   1 = auto-animate, 0 = use frame_sel
//   frame_sel    in   static frame when anim_en = 0
//   rom_address  out  registered sprite ROM address (held on a miss)
//   rom_q        in   ROM data for the address presented one cycle earlier
//   pix_idx      out  palette index, 0 whenever pix_opaque = 0
//   pix_opaque   out  sprite covers this pixel with a visible texel
//   blank_d      out  blank aligned with pix_*
//   frame_start  out  one-cycle pulse after (0,0) is sampled
// ============================================================================
module sprite_blitter
    import sprite_pkg::*;
#(
    parameter int SPRITE_W        = 64,
    parameter int SPRITE_H        = 64,
    parameter int NUM_FRAMES      = 4,
    parameter int IDX_BITS        = 4,
    parameter int SCALE_SHIFT     = 0,
    parameter int TRANSPARENT_IDX = 0,
    parameter int FRAME_TICKS     = 8,
    parameter int ADDR_W          = $clog2(NUM_FRAMES * SPRITE_W * SPRITE_H),
    localparam int FSEL_W = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
    input  logic                vga_clk,
    input  logic                reset_n,
    input  logic [9:0]          DrawX,
    input  logic [9:0]          DrawY,
    input  logic                blank,
    input  logic [9:0]          sprite_x,
    input  logic [9:0]          sprite_y,
    input  logic                sprite_en,
    input  logic                flip_h,
    input  logic                anim_en,
    input  logic [FSEL_W-1:0]   frame_sel,
    output logic [ADDR_W-1:0]   rom_address,
    input  logic [IDX_BITS-1:0] rom_q,
    output logic [IDX_BITS-1:0] pix_idx,
    output logic                pix_opaque,
    output logic                blank_d,
    output logic                frame_start
);

    localparam int unsigned W_LOG2 = $clog2(SPRITE_W);
    localparam int unsigned H_LOG2 = $clog2(SPRITE_H);
    localparam int unsigned SPAN_W = SPRITE_W << SCALE_SHIFT;
    localparam int unsigned SPAN_H = SPRITE_H << SCALE_SHIFT;
    localparam logic [IDX_BITS-1:0] CLEAR_IDX = IDX_BITS'(TRANSPARENT_IDX);

    coord_t            sx;
    coord_t            sy;
    logic              s_en;
    logic              s_flip;
    logic [FSEL_W-1:0] frame_idx;

    coord_wide_t       dx;
    coord_wide_t       dy;
    coord_wide_t       col;
    coord_wide_t       row;
    logic              hit_x;
    logic              hit_y;
    logic              hit;
    logic [ADDR_W-1:0] addr_next;

    logic              hit_s1;
    logic              blank_s1;
    logic              opaque_next;

    sprite_anim_ctrl #(
        .NUM_FRAMES  (NUM_FRAMES),
        .FRAME_TICKS (FRAME_TICKS)
    ) u_anim (
        .vga_clk     (vga_clk),
        .reset_n     (reset_n),
        .DrawX       (DrawX),
        .DrawY       (DrawY),
        .sprite_x    (sprite_x),
        .sprite_y    (sprite_y),
        .sprite_en   (sprite_en),
        .flip_h      (flip_h),
        .anim_en     (anim_en),
        .frame_sel   (frame_sel),
        .frame_start (frame_start),
        .sx          (sx),
        .sy          (sy),
        .s_en        (s_en),
        .s_flip      (s_flip),
        .frame_idx   (frame_idx)
    );

    // Hit test on 11-bit values: the extra bit keeps sx + span from wrapping
    // back to column 0 when the sprite hangs off the right or bottom edge.
    // The "DrawX >= sx" term rejects the wrapped-negative dx on the left.
    always_comb begin
        dx    = {1'b0, DrawX} - {1'b0, sx};
        dy    = {1'b0, DrawY} - {1'b0, sy};
        hit_x = (DrawX >= sx) && (32'(dx) < SPAN_W);
        hit_y = (DrawY >= sy) && (32'(dy) < SPAN_H);
        hit   = hit_x && hit_y && s_en;
    end

    // Scaling drops the low offset bits so each texel repeats over a
    // 2^SCALE_SHIFT square of screen pixels.
    always_comb begin
        col       = dx >> SCALE_SHIFT;
        row       = dy >> SCALE_SHIFT;
        addr_next = ADDR_W'(sprite_addr(32'(frame_idx), 32'(row), 32'(col),
                                        s_flip, W_LOG2, H_LOG2));
    end

    assign opaque_next = hit_s1 && blank_s1 && (rom_q != CLEAR_IDX);

    // Two-stage pipeline. Stage 0 presents the address and carries hit/blank
    // alongside it; stage 1 captures the ROM word that answers that address.
    // On a miss the address is held so the ROM input only toggles while the
    // raster is inside the sprite. Clearing hit_s1 on reset keeps a stale hit
    // from surfacing as pix_opaque after reset is released.
    always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
            rom_address <= '0;
            hit_s1      <= 1'b0;
            blank_s1    <= 1'b0;
            pix_idx     <= '0;
            pix_opaque  <= 1'b0;
            blank_d     <= 1'b0;
        end else begin
            if (hit)
                rom_address <= addr_next;
            hit_s1     <= hit;
            blank_s1   <= blank;
            pix_opaque <= opaque_next;
            pix_idx    <= opaque_next ? rom_q : '0;
            blank_d    <= blank_s1;
        end
    end

endmodule

// File: tb/tb_sprite_blitter.sv
// ============================================================================
// tb_sprite_blitter
// ----------------------------------------------------------------------------
// Directed bench for sprite_blitter. Instance dut uses default parameters;
// instance dut2 uses SCALE_SHIFT=1, FRAME_TICKS=2 with the sprite parked at
// (0,0). Both share the raster inputs. The ROM model is combinational from the
// registered rom_address: texel value = (address[3:0] + 5) mod 16, so address 0
// reads 5 and address 11 reads the transparent index 0.
// ============================================================================
module tb_sprite_blitter;

    logic        vga_clk;
    logic        reset_n;
    logic        reset_n2;
    logic [9:0]  DrawX;
    logic [9:0]  DrawY;
    logic        blank;

    logic [9:0]  sprite_x;
    logic [9:0]  sprite_y;
    logic        sprite_en;
    logic        flip_h;
    logic        anim_en;
    logic [1:0]  frame_sel;
    logic [13:0] rom_address;
    logic [3:0]  rom_q;
    logic [3:0]  pix_idx;
    logic        pix_opaque;
    logic        blank_d;
    logic        frame_start;

    logic        anim_en2;
    logic [13:0] rom_address2;
    logic [3:0]  rom_q2;
    logic [3:0]  pix_idx2;
    logic        pix_opaque2;
    logic        blank_d2;
    logic        frame_start2;

    int checks = 0;
    int errors = 0;

    sprite_blitter dut (
        .vga_clk     (vga_clk),
        .reset_n     (reset_n),
        .DrawX       (DrawX),
        .DrawY       (DrawY),
        .blank       (blank),
        .sprite_x    (sprite_x),
        .sprite_y    (sprite_y),
        .sprite_en   (sprite_en),
        .flip_h      (flip_h),
        .anim_en     (anim_en),
        .frame_sel   (frame_sel),
        .rom_address (rom_address),
        .rom_q       (rom_q),
        .pix_idx     (pix_idx),
        .pix_opaque  (pix_opaque),
        .blank_d     (blank_d),
        .frame_start (frame_start)
    );

    sprite_blitter #(
        .SCALE_SHIFT (1),
        .FRAME_TICKS (2)
    ) dut2 (
        .vga_clk     (vga_clk),
        .reset_n     (reset_n2),
        .DrawX       (DrawX),
        .DrawY       (DrawY),
        .blank       (blank),
        .sprite_x    (10'd0),
        .sprite_y    (10'd0),
        .sprite_en   (1'b1),
        .flip_h      (1'b0),
        .anim_en     (anim_en2),
        .frame_sel   (2'd0),
        .rom_address (rom_address2),
        .rom_q       (rom_q2),
        .pix_idx     (pix_idx2),
        .pix_opaque  (pix_opaque2),
        .blank_d     (blank_d2),
        .frame_start (frame_start2)
    );

    // Sprite ROM models; the registered rom_address acts as the ROM's
    // address register, so data follows it within the same cycle.
    assign rom_q  = rom_address[3:0] + 4'd5;
    assign rom_q2 = rom_address2[3:0] + 4'd5;

    // Pixel clock, 10 time units per cycle.
    initial vga_clk = 1'b0;
    always #5 vga_clk = ~vga_clk;

    // Drive one raster position and advance one clock, leaving time 1 unit
    // past the edge so registered outputs are settled for checking.
    task automatic applyStimulus(input int x, input int y, input logic b);
        DrawX = 10'(x);
        DrawY = 10'(y);
        blank = b;
        @(posedge vga_clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
            $error("[TB] check %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Sample one pixel on dut, check the address one cycle later and the
    // palette outputs two cycles later (idle position fed in between).
    task automatic probe(input string tag, input int x, input int y, input logic b,
                         input int exp_addr, input int exp_opq, input int exp_idx);
        applyStimulus(x, y, b);
        checkOutput({tag, "_addr"}, 32'(rom_address), exp_addr);
        applyStimulus(639, 479, 1'b1);
        checkOutput({tag, "_opaque"}, 32'(pix_opaque), exp_opq);
        checkOutput({tag, "_idx"}, 32'(pix_idx), exp_idx);
        checkOutput({tag, "_blank_d"}, 32'(blank_d), 32'(b));
    endtask

    // One frame start: (0,0) then an idle pixel; frame_start must pulse for
    // exactly one cycle on both instances.
    task automatic framePulse(input string tag);
        applyStimulus(0, 0, 1'b1);
        checkOutput({tag, "_fs_hi"}, 32'(frame_start), 1);
        checkOutput({tag, "_fs2_hi"}, 32'(frame_start2), 1);
        applyStimulus(639, 479, 1'b1);
        checkOutput({tag, "_fs_lo"}, 32'(frame_start), 0);
        checkOutput({tag, "_fs2_lo"}, 32'(frame_start2), 0);
    endtask

    int anim_seq [10] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};

    initial begin
        $display("[TB] start");
        reset_n   = 1'b0;
        reset_n2  = 1'b0;
        sprite_x  = 10'd100;
        sprite_y  = 10'd50;
        sprite_en = 1'b1;
        flip_h    = 1'b0;
        anim_en   = 1'b0;
        frame_sel = 2'd0;
        anim_en2  = 1'b0;
        applyStimulus(639, 479, 1'b1);
        applyStimulus(639, 479, 1'b1);

        // Reset state
        checkOutput("rst_addr", 32'(rom_address), 0);
        checkOutput("rst_idx", 32'(pix_idx), 0);
        checkOutput("rst_opaque", 32'(pix_opaque), 0);
        checkOutput("rst_blank_d", 32'(blank_d), 0);
        checkOutput("rst_fs", 32'(frame_start), 0);

        reset_n  = 1'b1;
        reset_n2 = 1'b1;
        applyStimulus(639, 479, 1'b1);

        // Shadows still zero before the first frame start: sprite hidden
        probe("pre_fs", 100, 50, 1'b1, 0, 0, 0);

        framePulse("fs1");

        // Basic placement at (100,50)
        probe("origin", 100, 50, 1'b1, 0, 1, 5);
        probe("left_miss", 99, 50, 1'b1, 0, 0, 0);
        probe("right_miss", 164, 50, 1'b1, 0, 0, 0);
        probe("inner", 105, 52, 1'b1, 133, 1, 10);
        probe("transparent", 111, 50, 1'b1, 11, 0, 0);
        probe("blanked", 101, 50, 1'b0, 1, 0, 0);

        // Mirror + static frame 2 (needs two frame starts to reach the index)
        flip_h    = 1'b1;
        frame_sel = 2'd2;
        framePulse("fs_flip_a");
        framePulse("fs_flip_b");
        probe("flip_left", 100, 50, 1'b1, 8255, 1, 4);
        probe("flip_right", 163, 51, 1'b1, 8256, 1, 5);

        // Scaled instance: texel covers 2x2 pixels, sprite spans 128x128
        applyStimulus(2, 0, 1'b1);
        checkOutput("scale_2_0", 32'(rom_address2), 1);
        applyStimulus(0, 0, 1'b1);
        checkOutput("scale_0_0", 32'(rom_address2), 0);
        applyStimulus(2, 0, 1'b1);
        applyStimulus(1, 1, 1'b1);
        checkOutput("scale_1_1", 32'(rom_address2), 0);
        applyStimulus(127, 127, 1'b1);
        checkOutput("scale_127", 32'(rom_address2), 4095);
        applyStimulus(128, 0, 1'b1);
        checkOutput("scale_128_hold", 32'(rom_address2), 4095);
        applyStimulus(639, 479, 1'b1);
        checkOutput("scale_128_opaque", 32'(pix_opaque2), 0);
        applyStimulus(639, 479, 1'b1);

        // Auto animation on the scaled instance, frame read back via address
        anim_en2 = 1'b1;
        for (int k = 0; k < 10; k++) begin
            framePulse($sformatf("anim%0d", k));
            applyStimulus(2, 0, 1'b1);
            checkOutput($sformatf("anim%0d_addr", k), 32'(rom_address2), anim_seq[k] * 4096 + 1);
            applyStimulus(639, 479, 1'b1);
        end

        // Sprite near the right edge: no wrap onto the left columns
        sprite_x  = 10'd600;
        flip_h    = 1'b0;
        frame_sel = 2'd0;
        framePulse("fs_edge_a");
        framePulse("fs_edge_b");
        probe("edge_600", 600, 50, 1'b1, 0, 1, 5);
        probe("edge_639", 639, 50, 1'b1, 39, 1, 12);
        probe("edge_wrap0", 0, 50, 1'b1, 39, 0, 0);
        probe("edge_wrap23", 23, 50, 1'b1, 39, 0, 0);

        // Mid-frame move is ignored until the next frame start
        sprite_x = 10'd100;
        probe("midframe", 100, 50, 1'b1, 39, 0, 0);
        framePulse("fs_move");
        probe("moved", 100, 50, 1'b1, 0, 1, 5);

        // Mid-frame reset while the sprite is visible
        applyStimulus(100, 50, 1'b1);
        applyStimulus(101, 50, 1'b1);
        checkOutput("pre_rst_opaque", 32'(pix_opaque), 1);
        reset_n = 1'b0;
        applyStimulus(101, 50, 1'b1);
        checkOutput("mid_rst_addr", 32'(rom_address), 0);
        checkOutput("mid_rst_idx", 32'(pix_idx), 0);
        checkOutput("mid_rst_opaque", 32'(pix_opaque), 0);
        checkOutput("mid_rst_blank_d", 32'(blank_d), 0);
        checkOutput("mid_rst_fs", 32'(frame_start), 0);
        reset_n = 1'b1;
        probe("post_rst_hidden", 105, 52, 1'b1, 0, 0, 0);
        framePulse("fs_post_rst");
        probe("post_rst_shown", 105, 52, 1'b1, 133, 1, 10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sprite_blitter.md
Name: sprite_blitter

Overview:
- Parametrised sprite pixel source for the VGA pipeline. It replaces the full-screen stretched-sprite test path.
- Places a NUM_FRAMES-frame animated sprite at a runtime (x,y) with power-of-two scaling, horizontal flip and a transparent palette index.
- Drives an external synchronous sprite ROM. Emits a palette index plus an opaque flag to the downstream mixer/palette stage.

Parameters:
- SPRITE_W, 64: sprite width in texels. Power of two.
- SPRITE_H, 64: sprite height in texels. Power of two.
- NUM_FRAMES, 4: animation frames stored back-to-back in ROM. Minimum 1.
- IDX_BITS, 4: palette index width (ROM data width).
- SCALE_SHIFT, 0: each texel covers 2^SCALE_SHIFT × 2^SCALE_SHIFT screen pixels.
- TRANSPARENT_IDX, 0: ROM index treated as see-through.
- FRAME_TICKS, 8: video frames per animation step. Minimum 1.
- ADDR_W, $clog2(NUM_FRAMES*SPRITE_W*SPRITE_H): ROM address width. Derived; do not override.

Ports:
- vga_clk  in  1  pixel clock. All logic is on posedge.
- reset_n  in  1  synchronous, active-low reset.
- DrawX  in  10  current pixel column.
- DrawY  in  10  current pixel row.
- blank  in  1  1 = active video.
- sprite_x  in  10  requested left edge, screen pixels.
- sprite_y  in  10  requested top edge, screen pixels.
- sprite_en  in  1  request sprite visible.
- flip_h  in  1  mirror horizontally.
- anim_en  in  1  1 = auto-animate; 0 = use frame_sel.
- frame_sel  in  $clog2(NUM_FRAMES) (min 1)  static frame when anim_en=0.
- rom_address  out  ADDR_W  registered address to sprite ROM.
- rom_q  in  IDX_BITS  ROM data, valid one vga_clk after rom_address.
- pix_idx  out  IDX_BITS  palette index of sprite pixel.
- pix_opaque  out  1  1 = sprite covers this pixel, non-transparent, in active video.
- blank_d  out  1  blank delayed to align with pix_*.
- frame_start  out  1  one-cycle pulse when DrawX==0 and DrawY==0.

Behaviour:
- Clock and reset: one clock, vga_clk. reset_n is synchronous and active-low. While reset_n=0 at a posedge, every output and register clears to 0: rom_address, pix_idx, pix_opaque, blank_d, frame_start, shadow registers, frame index and tick counter.
- frame_start: registered pulse, asserted the cycle after DrawX==0 && DrawY==0 is sampled. It lasts exactly one cycle because DrawX advances every cycle.
- Shadow latch: on the cycle DrawX==0 && DrawY==0 is sampled, latch sprite_x, sprite_y, sprite_en, flip_h, anim_en and frame_sel into shadow registers. All pixel math uses the shadows, so there is no mid-frame tearing. After reset, shadows stay 0 (sprite hidden) until the first frame start.
- Animation:
  - The tick counter counts frame starts while shadow anim_en=1.
  - On reaching FRAME_TICKS-1 it clears and the frame index increments modulo NUM_FRAMES (NUM_FRAMES-1 wraps to 0).
  - When shadow anim_en=0: frame index loads shadow frame_sel (values ≥ NUM_FRAMES clamp to NUM_FRAMES-1) and the counter holds 0.
  - Frame index changes only at frame start.
- Hit test: 11-bit unsigned arithmetic, so a right or bottom edge near 639/479 never wraps.
  - dx = DrawX - sx; hit_x when DrawX ≥ sx and dx < SPRITE_W<<SCALE_SHIFT.
  - dy is computed likewise; hit = hit_x & hit_y & shadow sprite_en.
- Address:
  - col = dx>>SCALE_SHIFT; if flip then SPRITE_W-1-col.
  - row = dy>>SCALE_SHIFT.
  - addr = frame*SPRITE_W*SPRITE_H + row*SPRITE_W + col. The products are shifts/concats because W and H are powers of two.
  - On a miss, rom_address holds its previous value.
- Pipeline, fixed 2-cycle latency from DrawX/DrawY/blank sample to pix_*/blank_d:
  - S0 (posedge n): register rom_address, hit_s1 and blank_s1.
  - S1 (posedge n+1): ROM presents rom_q. Register pix_idx = rom_q.
    - pix_opaque = hit_s1 & blank_s1 & (rom_q != TRANSPARENT_IDX).
    - blank_d = blank_s1.
  - When pix_opaque=0, pix_idx is forced to 0.
- Reset mid-frame: outputs go to 0 on the next edge. The pipeline refills with no stale pix_opaque; the sprite stays hidden until the next frame start.
- Simultaneous events:
  - Register inputs changing on the frame-start cycle are the values latched.
  - A frame start coinciding with the tick wrap advances the frame exactly once.

Decomposition:
- Package sprite_pkg holds:
  - SCREEN_W=640 and SCREEN_H=480;
  - the coordinate type (10-bit) and the wide coordinate type (11-bit);
  - function sprite_addr(frame,row,col,flip) shared with future multi-sprite blocks.
- Sub-module sprite_anim_ctrl holds the frame-start detect, shadow latch, tick counter and frame index, with outputs to the top.
- The top holds the hit test, address generation and the 2-stage pipeline.

Test Plan:
- Default parameters, sprite_x=100, sprite_y=50, en=1, ROM texel0=5: sampling DrawX=100,DrawY=50 gives rom_address=0 next cycle, then pix_idx=5, pix_opaque=1 at +2. DrawX=99 and DrawX=164 give pix_opaque=0.
- flip_h=1, frame_sel=2, anim_en=0: pixel (100,50) addresses 2*4096+63=8255. Pixel (163,51) addresses 8192+64+0=8256.
- SCALE_SHIFT=1, sprite at (0,0): pixels (0,0),(1,1) both give address 0. (2,0) gives 1. (127,127) gives 4095. (128,0) is a miss.
- anim_en=1, FRAME_TICKS=2, NUM_FRAMES=4: the frame index sequence over 10 frame starts is 0,0,1,1,2,2,3,3,0,0 (wrap checked). frame_start pulses once per frame.
- ROM returns TRANSPARENT_IDX inside the sprite: pix_opaque=0 and pix_idx=0. blank=0 inside the sprite gives pix_opaque=0 and blank_d=0 two cycles later.
- sprite_x=600: hit for DrawX 600..639 with no wrap hit at DrawX 0..23. Changing sprite_x mid-frame has no effect until after the next frame start.
- Assert reset_n=0 for one cycle while pix_opaque=1: all outputs are 0 next cycle. There are no hits until the frame after the next frame start.
